// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: processes STEP bits per clock with a registered
// carry, behind a start/busy/done handshake.
module add_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_next;
  logic             w_accept, w_finish, w_last;
  logic [WIDTH-1:0] r_a, r_b, r_sum, w_full;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_done, r_co, r_ov;
  logic [WIDTH-1:0] r_s;
  logic [STEP:0]    w_chunk;

  // Operands shift right each cycle so the active chunk is always the low STEP
  // bits; partial sums enter at the top, so after N shifts r_sum is aligned.
  assign w_chunk = {1'b0, r_a[STEP-1:0]} + {1'b0, r_b[STEP-1:0]}
                 + {{STEP{1'b0}}, r_carry};
  assign w_full  = (r_sum >> STEP) | (WIDTH'(w_chunk[STEP-1:0]) << (WIDTH - STEP));
  assign w_last  = (r_cnt == CW'(N - 1));

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_finish = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_co    <= 1'b0;
      r_ov    <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= ci ^ sub;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> STEP;
        r_b     <= r_b >> STEP;
        r_sum   <= w_full;
        r_carry <= w_chunk[STEP];
        r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end
      // On the last chunk the low bits of r_a/r_b hold the original MSBs.
      if (w_finish) begin
        r_s  <= w_full;
        r_co <= w_chunk[STEP];
        r_ov <= (r_a[STEP-1] == r_b[STEP-1]) && (w_chunk[STEP-1] != r_a[STEP-1]);
      end
    end
  end

  assign busy = (r_state == RUN);
  assign done = r_done;
  assign s    = r_s;
  assign co   = r_co;
  assign ov   = r_ov;

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq over four WIDTH/STEP configurations,
// against an integer-arithmetic reference model.
module tb_add_seq;

  logic        clk = 1'b0;
  logic        rst, sub, ci;
  logic [31:0] a, b;
  logic [3:0]  st, bz, dn, cq, oq;
  logic [31:0] s32;
  logic [7:0]  s8 [1:3];

  int          nvec = 0;
  int          nerr = 0;
  int          cur  = 0;
  logic [31:0] w_s;
  int          wid [0:3] = '{32, 8, 8, 8};
  int          nlat[0:3] = '{4, 2, 8, 1};

  always #5 clk = ~clk;

  add_seq #(.WIDTH(32), .STEP(8)) u_w32s8 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .ci(ci), .a(a), .b(b),
    .busy(bz[0]), .done(dn[0]), .s(s32), .co(cq[0]), .ov(oq[0]));
  add_seq #(.WIDTH(8), .STEP(4)) u_w8s4 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .ci(ci), .a(a[7:0]), .b(b[7:0]),
    .busy(bz[1]), .done(dn[1]), .s(s8[1]), .co(cq[1]), .ov(oq[1]));
  add_seq #(.WIDTH(8), .STEP(1)) u_w8s1 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .ci(ci), .a(a[7:0]), .b(b[7:0]),
    .busy(bz[2]), .done(dn[2]), .s(s8[2]), .co(cq[2]), .ov(oq[2]));
  add_seq #(.WIDTH(8), .STEP(8)) u_w8s8 (
    .clk(clk), .rst(rst), .start(st[3]), .sub(sub), .ci(ci), .a(a[7:0]), .b(b[7:0]),
    .busy(bz[3]), .done(dn[3]), .s(s8[3]), .co(cq[3]), .ov(oq[3]));

  always_comb begin
    w_s = s32;
    if (cur != 0) w_s = {24'd0, s8[cur]};
  end

  // Reference: exact integer result, then wrap / borrow / signed-range tests.
  function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                input logic sb, input logic c, output logic [31:0] es,
                                output logic eco, output logic eov);
    longint m, ux, uy, sx, sy, full, sr;
    m  = longint'(1) << w;
    ux = longint'(x) & (m - 1);
    uy = longint'(y) & (m - 1);
    sx = (ux >= m / 2) ? ux - m : ux;
    sy = (uy >= m / 2) ? uy - m : uy;
    full = sb ? ux - uy - longint'(c) : ux + uy + longint'(c);
    sr   = sb ? sx - sy - longint'(c) : sx + sy + longint'(c);
    es  = 32'(full & (m - 1));
    eco = sb ? (full >= 0) : (full >= m);
    eov = (sr < -(m / 2)) || (sr >= m / 2);
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!dn[cur] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int c, input logic [31:0] ta, input logic [31:0] tb2,
                        input logic tsub, input logic tci, output int lat,
                        output logic [31:0] rs, output logic rco, output logic rov);
    cur = c;
    a = ta; b = tb2; sub = tsub; ci = tci; st[c] = 1'b1;
    @(posedge clk); #1;
    st[c] = 1'b0;
    wait_done(lat);
    rs = w_s; rco = cq[c]; rov = oq[c];
  endtask

  task automatic test_reset;
    rst = 1'b1; st = '0; a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cur = i; #0;
      nvec++;
      if ({bz[i], dn[i], cq[i], oq[i]} !== 4'b0000 || w_s !== 32'd0) begin
        nerr++;
        $display("FAIL reset cfg%0d: busy/done/co/ov=%b s=%h, required 0000 s=0",
                 i, {bz[i], dn[i], cq[i], oq[i]}, w_s);
      end
    end
  endtask

  task automatic test_run_hold;
    int cyc, bcnt;
    logic held;
    cur = 0; held = 1'b1;
    a = 32'hFFFF_FFFF; b = '0; sub = 1'b0; ci = 1'b1; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    a = $urandom; b = $urandom; sub = 1'b1; ci = 1'b0;
    cyc = 0; bcnt = 0;
    while (!dn[0] && cyc < 40) begin
      if (bz[0]) bcnt++;
      if (s32 !== 32'd0 || cq[0] !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    nvec++;
    if (bcnt != 4 || cyc != 4) begin
      nerr++; $display("FAIL run_busy: busy=%0d lat=%0d, required 4/4", bcnt, cyc);
    end
    nvec++;
    if (!held) begin
      nerr++; $display("FAIL run_hold: outputs changed during RUN, required held at 0");
    end
    nvec++;
    if (s32 !== 32'd0 || cq[0] !== 1'b1 || oq[0] !== 1'b0 || bz[0] !== 1'b0) begin
      nerr++;
      $display("FAIL run_result: s=%h co=%b ov=%b busy=%b, required 0 1 0 0",
               s32, cq[0], oq[0], bz[0]);
    end
    @(posedge clk); #1;
    nvec++;
    if (dn[0] !== 1'b0) begin
      nerr++; $display("FAIL done_pulse: done=%b one cycle later, required 0", dn[0]);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, ndone, lat;
    cur = 0;
    a = 32'd1; b = 32'd2; sub = 1'b0; ci = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0; cyc = 0; ndone = 0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    a = 32'd100; b = 32'd100; st[0] = 1'b1;
    @(posedge clk); #1; cyc++;
    st[0] = 1'b0;
    while (!dn[0] && cyc < 40) begin @(posedge clk); #1; cyc++; end
    nvec++;
    if (cyc != 4 || s32 !== 32'd3) begin
      nerr++; $display("FAIL ignored_start: lat=%0d s=%h, required 4 / 3", cyc, s32);
    end
    a = 32'd5; b = 32'd3; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    wait_done(lat);
    nvec++;
    if (lat != 4 || s32 !== 32'd8) begin
      nerr++; $display("FAIL back_to_back: lat=%0d s=%h, required 4 / 8", lat, s32);
    end
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (dn[0]) ndone++; end
    nvec++;
    if (ndone != 0) begin
      nerr++; $display("FAIL spurious_done: %0d extra done pulses, required 0", ndone);
    end
  endtask

  task automatic test_reset_mid;
    int ndone, lat;
    logic [31:0] rs; logic rco, rov;
    cur = 0;
    a = 32'd10; b = 32'd20; sub = 1'b0; ci = 1'b0; st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if ({bz[0], dn[0], cq[0], oq[0]} !== 4'b0000 || s32 !== 32'd0) begin
      nerr++;
      $display("FAIL reset_mid: busy/done/co/ov=%b s=%h, required 0000 s=0",
               {bz[0], dn[0], cq[0], oq[0]}, s32);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (dn[0]) ndone++; end
    nvec++;
    if (ndone != 0) begin
      nerr++; $display("FAIL reset_discard: %0d done pulses, required 0", ndone);
    end
    run_op(0, 32'd7, 32'd9, 1'b0, 1'b0, lat, rs, rco, rov);
    nvec++;
    if (lat != 4 || rs !== 32'd16 || rco !== 1'b0 || rov !== 1'b0) begin
      nerr++;
      $display("FAIL after_reset: lat=%0d s=%h co=%b ov=%b, required 4 10 0 0",
               lat, rs, rco, rov);
    end
  endtask

  task automatic test_w8s4;
    logic [31:0] va [0:3] = '{32'hFF, 32'h7F, 32'h80, 32'h00};
    logic [31:0] vb [0:3] = '{32'h01, 32'h01, 32'h01, 32'h01};
    logic        vs [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] xs [0:3] = '{32'h00, 32'h80, 32'h7F, 32'hFF};
    logic        xc [0:3] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        xo [0:3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    logic [31:0] rs; logic rco, rov;
    for (int i = 0; i < 4; i++) begin
      run_op(1, va[i], vb[i], vs[i], 1'b0, lat, rs, rco, rov);
      nvec++;
      if (lat != 2 || rs !== xs[i] || rco !== xc[i] || rov !== xo[i]) begin
        nerr++;
        $display("FAIL w8s4_vec%0d: lat=%0d s=%h co=%b ov=%b, required 2 %h %b %b",
                 i, lat, rs, rco, rov, xs[i], xc[i], xo[i]);
      end
    end
  endtask

  task automatic test_sweep(input int c);
    int lat, bad;
    logic [31:0] ta, tb2, rs, es;
    logic tsub, tci, rco, rov, eco, eov;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      ta = $urandom_range(255); tb2 = $urandom_range(255);
      tsub = 1'($urandom); tci = 1'($urandom);
      if (i < 4) begin ta = (i[0]) ? 32'hFF : 32'h80; tb2 = (i[1]) ? 32'hFF : 32'h7F; end
      run_op(c, ta, tb2, tsub, tci, lat, rs, rco, rov);
      model(wid[c], ta, tb2, tsub, tci, es, eco, eov);
      nvec++;
      if (lat != nlat[c] || rs !== es || rco !== eco || rov !== eov) begin
        nerr++;
        if (bad < 10)
          $display("FAIL sweep_cfg%0d a=%h b=%h sub=%b ci=%b: lat=%0d s=%h co=%b ov=%b, required %0d %h %b %b",
                   c, ta, tb2, tsub, tci, lat, rs, rco, rov, nlat[c], es, eco, eov);
        bad++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_run_hold;
    test_back_to_back;
    test_reset_mid;
    test_w8s4;
    test_sweep(2);
    test_sweep(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/add_seq.md
# add_seq

Parametrised multi-cycle adder/subtractor: the wide-operand successor to the fixed 8-bit ripple adder. It adds or subtracts two WIDTH-bit operands STEP bits per clock, with a registered carry between chunks, so wide adds fit a short critical path. It sits behind a start/busy/done handshake, so a controller or datapath sequencer can issue operations and collect the sum, carry-out and signed overflow.

## Interface
- WIDTH, 32, operand/result width in bits; must be an integer multiple of STEP
- STEP, 8, bits processed per clock (1..WIDTH); N = WIDTH/STEP is the cycle count
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request; accepted only when busy=0
- sub  input  1  0: s = a + b + ci; 1: s = a - b - ci
- ci  input  1  carry-in (add) or borrow-in (sub)
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B, sampled at accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- s  output  WIDTH  result
- co  output  1  raw carry-out of the MSB; in sub mode 1 = no borrow
- ov  output  1  two's-complement signed overflow

## Operation
- States: IDLE (busy=0) and RUN (busy=1). done is a registered flag, not a state.
- Accept: start=1 and busy=0 at a clock edge.
  - Latch a.
  - Latch b, or ~b when sub=1.
  - Carry register loads ci when sub=0 and ~ci when sub=1.
  - Chunk counter loads 0. Go to RUN.
- RUN: each edge adds chunk k (bits k*STEP+STEP-1 : k*STEP) of the latched A and B plus the carry register. It stores the STEP-bit partial sum, updates the carry, and increments k.
- After chunk N-1:
  - s gets the full sum; co gets the final carry.
  - ov = (A[W-1] == B'[W-1]) and (s[W-1] != A[W-1]), where B' is the latched (possibly inverted) B.
  - done pulses; return to IDLE.
- s, co and ov change only on completion. They hold the previous result during RUN and while idle.
- Operands and sub are sampled only at accept. Later changes to a, b, sub or ci have no effect on the operation in flight.
- start while busy=1 is ignored: no queueing, no error.
- Back-to-back: start in the cycle done=1 is accepted, since busy is already 0.
- Arithmetic is modulo 2^WIDTH.

## Timing
- Reset values: busy=0, done=0, s=0, co=0, ov=0. State is IDLE and the counter is 0.
- rst=1 at any edge, including mid-RUN, forces the reset values. The in-flight operation is discarded and produces no done.
- rst has priority over start at the same edge.
- Accept at edge E:
  - busy=1 from E through edge E+N.
  - At edge E+N: busy=0, done=1, s/co/ov valid.
  - done falls at edge E+N+1 unless another op completes there.
- Latency is N cycles from accept to done, so throughput is one op per N cycles.
- STEP=WIDTH gives N=1: done one cycle after accept, with busy high for exactly one cycle.
- No combinational path from inputs to outputs.

## Test plan
- WIDTH=8, STEP=4, add a=0xFF, b=0x01, ci=0. Required: done 2 cycles after accept; s=0x00, co=1, ov=0. Then a=0x7F, b=0x01. Required: s=0x80, co=0, ov=1.
- WIDTH=8, STEP=4, sub a=0x80, b=0x01, ci=0. Required: s=0x7F, co=1, ov=1. Then sub a=0x00, b=0x01. Required: s=0xFF, co=0 (borrow), ov=0.
- Defaults (32/8), add a=0xFFFFFFFF, b=0, ci=1. Required: busy high 4 cycles, then s=0x00000000, co=1, done pulse exactly 1 cycle. Change a/b during RUN; the result must be unaffected.
- Defaults, start pulsed again 2 cycles after accept. Required: ignored, single done at cycle 4. Then start during the done cycle with a=5, b=3. Required: accepted; next done 4 cycles later with s=8.
- Defaults, rst=1 for one edge 2 cycles into RUN. Required: busy=0, done=0, s=0, co=0, ov=0 after that edge, and no done afterwards. A subsequent op completes normally.
- Sweep STEP=1 and STEP=WIDTH with WIDTH=8. Run 1000 random a/b/ci/sub per configuration against a reference model. Required: s/co/ov match, and latency is 8 and 1 cycles respectively.
